// File: rtl/stream_mux.sv
// stream_mux: NUM_CH-to-1 registered stream multiplexer with packet locking and a forced-select mode.
// Define STREAM_MUX_RR_EN for round-robin arbitration; when it is undefined, the lowest-index valid channel wins.
module stream_mux #(
    parameter int  DATA_WIDTH = 16,
    parameter int  NUM_CH     = 4,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] d,
    input  logic [NUM_CH-1:0]            d_valid,
    input  logic [NUM_CH-1:0]            d_last,
    output logic [NUM_CH-1:0]            d_ready,
    input  logic                         force_en,
    input  logic [SEL_W-1:0]             force_sel,
    output logic [DATA_WIDTH-1:0]        q,
    output logic                         q_valid,
    output logic                         q_last,
    output logic [SEL_W-1:0]             q_ch,
    input  logic                         q_ready
);
    typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    state_t                  state_r, state_next_s;
    logic [SEL_W-1:0]        lock_ch_r, lock_ch_next_s;
    logic [SEL_W-1:0]        grant_s;
    logic                    grant_valid_s;
    logic                    load_en_s;
    logic                    xfer_s;
    logic [DATA_WIDTH-1:0]   d_sel_s;
    logic [NUM_CH-1:0]       d_ready_s;
    logic [DATA_WIDTH-1:0]   q_r;
    logic                    q_valid_r;
    logic                    q_last_r;
    logic [SEL_W-1:0]        q_ch_r;
`ifdef STREAM_MUX_RR_EN
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] ONE_CH  = SEL_W'(1);
    logic [SEL_W-1:0]        ptr_r, ptr_next_s;
`endif

    assign load_en_s = !q_valid_r || q_ready;
    // grant_valid_s already implies the granted channel has a valid beat
    assign xfer_s    = load_en_s && grant_valid_s;

    // Arbitration: the locked channel, the forced channel, or a priority search from the pointer/channel 0
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant_s       = '0;
        grant_valid_s = 1'b0;
        idx           = '0;
        if (state_r == LOCKED) begin
            grant_s       = lock_ch_r;
            grant_valid_s = d_valid[lock_ch_r];
        end else if (force_en) begin
            if ({1'b0, force_sel} < NUM_CH_W) begin
                grant_s       = force_sel;
                grant_valid_s = d_valid[force_sel];
            end else begin
                grant_s       = '0;
                grant_valid_s = 1'b0;
            end
        end else begin
            // Scan from the lowest priority down so the highest-priority valid channel is written last
            for (int k = NUM_CH - 1; k >= 0; k--) begin
`ifdef STREAM_MUX_RR_EN
                idx = SEL_W'((int'(ptr_r) + k) % NUM_CH);
`else
                idx = SEL_W'(k);
`endif
                if (d_valid[idx]) begin
                    grant_s       = idx;
                    grant_valid_s = 1'b1;
                end else begin
                    grant_s       = grant_s;
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // Payload select for the granted channel and the one-hot ready
    always_comb begin
        d_sel_s   = '0;
        d_ready_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_s == SEL_W'(k)) begin
                d_sel_s = d[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                d_sel_s = d_sel_s;
            end
        end
        if (xfer_s) begin
            d_ready_s[grant_s] = 1'b1;
        end else begin
            d_ready_s = '0;
        end
    end

    assign d_ready = d_ready_s;

    // Lock FSM next state: a non-last beat in IDLE locks onto its channel, a last beat unlocks
    always_comb begin
        state_next_s   = state_r;
        lock_ch_next_s = lock_ch_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && !d_last[grant_s]) begin
                    state_next_s   = LOCKED;
                    lock_ch_next_s = grant_s;
                end else begin
                    state_next_s   = IDLE;
                    lock_ch_next_s = lock_ch_r;
                end
            end
            LOCKED: begin
                if (xfer_s && d_last[grant_s]) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: begin
                state_next_s   = IDLE;
                lock_ch_next_s = '0;
            end
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            lock_ch_r <= '0;
        end else begin
            state_r   <= state_next_s;
            lock_ch_r <= lock_ch_next_s;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Pointer moves just past every granted channel, wrapping at NUM_CH
    always_comb begin
        ptr_next_s = ptr_r;
        if (xfer_s) begin
            ptr_next_s = (grant_s == LAST_CH) ? '0 : grant_s + ONE_CH;
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end
`endif

    // Output pipeline register: load on transfer, drain when free, hold on back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
            q_last_r  <= 1'b0;
            q_ch_r    <= '0;
        end else if (xfer_s) begin
            q_r       <= d_sel_s;
            q_valid_r <= 1'b1;
            q_last_r  <= d_last[grant_s];
            q_ch_r    <= grant_s;
        end else if (load_en_s) begin
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= q_valid_r;
        end
    end

    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign q_last  = q_last_r;
    assign q_ch    = q_ch_r;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a queue-free behavioural model checked every cycle, plus literal expectations.
module tb_stream_mux;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] d;
    logic [N-1:0]    d_valid, d_last, d_ready;
    logic            force_en;
    logic [SW-1:0]   force_sel;
    logic [DW-1:0]   q;
    logic            q_valid, q_last;
    logic [SW-1:0]   q_ch;
    logic            q_ready;

    logic [3*DW-1:0] d3;
    logic [2:0]      dv3, dl3, dr3;
    logic            fen3, qv3, ql3, qr3;
    logic [1:0]      fsel3, qch3;
    logic [DW-1:0]   q3;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: what the output register and lock/pointer must hold
    bit            m_locked = 1'b0;
    int            m_lch    = 0;
    int            m_ptr    = 0;
    logic [DW-1:0] m_q      = '0;
    bit            m_qv     = 1'b0;
    bit            m_ql     = 1'b0;
    logic [SW-1:0] m_qch    = '0;

    always #5 clk = ~clk;

    stream_mux #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_last(d_last), .d_ready(d_ready),
        .force_en(force_en), .force_sel(force_sel), .q(q), .q_valid(q_valid), .q_last(q_last),
        .q_ch(q_ch), .q_ready(q_ready)
    );

    stream_mux #(.DATA_WIDTH(DW), .NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .d(d3), .d_valid(dv3), .d_last(dl3), .d_ready(dr3),
        .force_en(fen3), .force_sel(fsel3), .q(q3), .q_valid(qv3), .q_last(ql3),
        .q_ch(qch3), .q_ready(qr3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return 1'(v >> i);
    endfunction

    // Which channel the rules say may transfer this cycle (-1 = none)
    function automatic int pick();
        int c;
        if (m_locked) return bit_at(d_valid, m_lch) ? m_lch : -1;
        if (force_en) return (int'(force_sel) < N && bit_at(d_valid, int'(force_sel))) ? int'(force_sel) : -1;
        for (int k = 0; k < N; k++) begin
`ifdef STREAM_MUX_RR_EN
            c = (m_ptr + k) % N;
`else
            c = k;
`endif
            if (bit_at(d_valid, c)) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] one;
        one = 1;
        g = pick();
        return ((!m_qv || q_ready) && g >= 0) ? (one << g) : '0;
    endfunction

    task automatic compare_cycle();
        check("cmp_q_valid", 64'(q_valid), 64'(m_qv));
        check("cmp_q", 64'(q), 64'(m_q));
        check("cmp_q_last", 64'(q_last), 64'(m_ql));
        check("cmp_q_ch", 64'(q_ch), 64'(m_qch));
        check("cmp_d_ready", 64'(d_ready), 64'(exp_ready()));
    endtask

    // Compare DUT with model mid-cycle, then advance the model over the coming rising edge
    always @(negedge clk or negedge rst_n) begin
        int  g;
        bit  ld;
        if (!rst_n) begin
            if (!clk) compare_cycle();
            m_locked <= 1'b0; m_lch <= 0; m_ptr <= 0;
            m_q <= '0; m_qv <= 1'b0; m_ql <= 1'b0; m_qch <= '0;
        end else begin
            compare_cycle();
            g  = pick();
            ld = !m_qv || q_ready;
            if (ld && g >= 0) begin
                m_q   <= DW'(d >> (g * DW));
                m_ql  <= bit_at(d_last, g);
                m_qch <= SW'(g);
                m_qv  <= 1'b1;
                m_ptr <= (g + 1) % N;
                if (!m_locked && !bit_at(d_last, g)) begin
                    m_locked <= 1'b1;
                    m_lch    <= g;
                end else if (m_locked && bit_at(d_last, g)) begin
                    m_locked <= 1'b0;
                end
            end else if (ld) begin
                m_qv <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [DW-1:0] v);
        d[i*DW +: DW] = v;
    endtask

    int exp_seq[4];

    initial begin
        q_ready = 1'b1; force_en = 1'b0; force_sel = '0;
        d_valid = 4'hF; d_last = 4'hF;
        for (int i = 0; i < N; i++) set_ch(i, DW'(16'hC000 + i));
        d3 = '0; dv3 = '0; dl3 = '0; fen3 = 1'b0; fsel3 = '0; qr3 = 1'b1;

        // reset with every channel valid
        repeat (3) tick();
        check("rst_q_valid", 64'(q_valid), 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_q_last", 64'(q_last), 64'd0);
        check("rst_q_ch", 64'(q_ch), 64'd0);
        rst_n = 1'b1;
        tick();
        check("first_q_valid", 64'(q_valid), 64'd1);
        check("first_q_ch", 64'(q_ch), 64'd0);
        check("first_q", 64'(q), 64'hC000);

        // single-beat packets on every channel
`ifdef STREAM_MUX_RR_EN
        exp_seq = '{1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arb_seq_q_ch", 64'(q_ch), 64'(exp_seq[i]));
        end

        // 3-beat packet on channel 2, force changed mid-packet
        d_valid = 4'b0111; d_last = 4'b0011; force_en = 1'b1; force_sel = 2'd2;
        set_ch(0, 16'h0A00); set_ch(1, 16'h1A00); set_ch(2, 16'h2001);
        #1 check("lock_rdy1", 64'(d_ready), 64'b0100);
        tick();
        check("lock_b1_ch", 64'(q_ch), 64'd2);
        check("lock_b1_q", 64'(q), 64'h2001);
        force_sel = 2'd0; set_ch(2, 16'h2002);
        #1 check("lock_rdy2", 64'(d_ready), 64'b0100);
        tick();
        check("lock_b2_ch", 64'(q_ch), 64'd2);
        force_en = 1'b0; d_last = 4'b0111; set_ch(2, 16'h2003);
        #1 check("lock_rdy3", 64'(d_ready), 64'b0100);
        tick();
        check("lock_b3_ch", 64'(q_ch), 64'd2);
        check("lock_b3_last", 64'(q_last), 64'd1);
        d_last = 4'b0011;
        tick();
        check("unlock_ch", 64'(q_ch), 64'd0);
        check("unlock_q", 64'(q), 64'h0A00);

        // forced channel 3 with back-pressure toggling
        d_valid = 4'hF; d_last = 4'hF; force_en = 1'b1; force_sel = 2'd3; set_ch(3, 16'h3003);
        #1 check("force_rdy", 64'(d_ready), 64'b1000);
        tick();
        check("force_ch", 64'(q_ch), 64'd3);
        q_ready = 1'b0;
        #1 check("force_stall_rdy", 64'(d_ready), 64'b0000);
        tick();
        q_ready = 1'b1;
        #1 check("force_rel_rdy", 64'(d_ready), 64'b1000);
        tick();

        // hold 0xA5A5 under 5 cycles of back-pressure
        force_sel = 2'd1; set_ch(1, 16'hA5A5);
        tick();
        check("stall_load", 64'(q), 64'hA5A5);
        set_ch(1, 16'h5A5A); q_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("stall_rdy", 64'(d_ready), 64'b0000);
            tick();
            check("stall_q", 64'(q), 64'hA5A5);
        end
        q_ready = 1'b1;
        #1 check("stall_rel_rdy", 64'(d_ready), 64'b0010);
        tick();
        check("stall_rel_q", 64'(q), 64'h5A5A);
        check("stall_rel_valid", 64'(q_valid), 64'd1);

        // nothing valid: register drains
        d_valid = 4'h0; force_en = 1'b0;
        tick();
        check("idle_valid", 64'(q_valid), 64'd0);
        check("idle_hold_q", 64'(q), 64'h5A5A);

        // reset during beat 2 of a locked packet on channel 1
        d_valid = 4'hF; d_last = 4'b1101; force_en = 1'b1; force_sel = 2'd1; set_ch(1, 16'h1B01);
        tick();
        check("mid_b1_ch", 64'(q_ch), 64'd1);
        check("mid_b1_last", 64'(q_last), 64'd0);
        set_ch(1, 16'h1B02);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", 64'(q_valid), 64'd0);
        tick();
        rst_n = 1'b1; force_en = 1'b0; d_last = 4'hF;
        tick();
        check("post_rst_ch", 64'(q_ch), 64'd0);
        check("post_rst_q", 64'(q), 64'h0A00);

        // 3-channel instance: out-of-range forced select grants nothing
        d3 = {16'h03C2, 16'h03C1, 16'h03C0}; dv3 = 3'b111; dl3 = 3'b111;
        tick();
        check("ch3_valid", 64'(qv3), 64'd1);
        check("ch3_q_ch", 64'(qch3), 64'd0);
        fen3 = 1'b1; fsel3 = 2'd3;
        #1 check("ch3_oor_rdy", 64'(dr3), 64'b000);
        tick();
        check("ch3_oor_valid", 64'(qv3), 64'd0);
        fsel3 = 2'd2;
        #1 check("ch3_sel2_rdy", 64'(dr3), 64'b100);
        tick();
        check("ch3_sel2_ch", 64'(qch3), 64'd2);
        check("ch3_sel2_q", 64'(q3), 64'h03C2);

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
